result_readback: RTL and testbench
==================================

Name: result_readback

Overview:
- Read-side responder for the integrator results (iq_valid, i_val, q_val).
- Captures each completed I/Q measurement into a FIFO.
- Serves the FIFO to the host over a read port that uses the same MEM_sdi_mem_S addressing as the config write bus, with status, head-of-queue and flush registers.
- Sits beside config_params on the host side of the top level.

Parameters:
- DEPTH, 64, FIFO entries; power of two, 2..4096.
- ADDR_BASE, 14'h3F00, base of this block's 8-word read window.

Ports:
- clk100  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- iq_valid  in  1  one-cycle strobe: i_val/q_val hold a new result.
- i_val  in  32  integrated I result.
- q_val  in  32  integrated Q result.
- MEM_sdi_mem_S_address  in  14  host read address.
- MEM_sdi_mem_S_rdEn  in  1  host read request, one cycle per read.
- MEM_sdi_mem_S_rdData  out  33  read data; bit 32 = entry-valid flag.
- MEM_sdi_mem_S_rdValid  out  1  read response strobe.
- fifo_count  out  13  current occupancy.
- overflow  out  1  sticky: a result was dropped.
- data_ready  out  1  high while fifo_count != 0.

Behaviour:
- Clock and reset: one clock (clk100); reset is synchronous and active-high.
- Reset values: rdData=0, rdValid=0, fifo_count=0, overflow=0, data_ready=0; pointers, drop_count and hold register cleared; FSM goes to IDLE.
- Reset mid-operation: all queued data is discarded and outputs return to their reset values.
- Push: on iq_valid and not full, write {i_val, q_val} at wr_ptr; wr_ptr increments, wrapping mod DEPTH.
- Push when full: entry dropped, overflow set, 16-bit drop_count increments (saturates at 0xFFFF). No pointer change.
- Read latency: rdValid pulses exactly 1 cycle after rdEn, with rdData valid in that same cycle; otherwise rdValid=0 and rdData holds its last value.
- Back-to-back rdEn every cycle is supported.
- Register map (offset from ADDR_BASE):
  - +0 STATUS: {1'b1, drop_count[15:0], overflow, full, empty, count[12:0]}.
  - +1 I_HEAD: if not empty, latch head {I,Q} into hold register, return {1'b1, I}, FSM to HELD. If empty, return 33'h0 and stay in IDLE.
  - +2 Q_HEAD: in HELD, return {1'b1, held Q}, pop the head, go to IDLE. In IDLE and not empty, return {1'b1, head Q} and pop. In IDLE and empty, return 33'h0 with no pop.
  - +3 FLUSH: returns {1'b1, 19'b0, count}. Then rd_ptr=wr_ptr, overflow=0, drop_count=0, FSM to IDLE.
  - +4 TS_HEAD: see Optional Feature.
  - +5..+7 and any address outside the window: return 33'h0, no side effects. rdValid still pulses, including for addresses outside the window.
- FSM states:
  - IDLE: no entry held.
  - HELD: head entry latched by an I_HEAD read.
  - Transitions are as listed under the register map. A repeated I_HEAD read while in HELD re-latches the current head and does not pop.
- Simultaneous push and pop in one cycle: both happen; count unchanged. When full, a simultaneous pop frees a slot, so the push is accepted, not dropped.
- Simultaneous iq_valid and FLUSH read: the flush applies first and the push is then stored, so count=1 afterwards.
- fifo_count, overflow and data_ready are registered and reflect state as of the previous edge.
- Storage: inferred simple dual-port RAM, 64 bits wide (96 bits with the optional feature). Occupancy is tracked with pointers that carry one extra wrap bit.

Optional Feature:
- Macro: RESULT_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter is added; it resets to 0 and wraps.
  - The counter value is stored with each pushed entry and latched into the hold register alongside I/Q by I_HEAD.
  - TS_HEAD returns {1'b1, timestamp} in HELD and 33'h0 in IDLE.
- Undefined: no counter or timestamp storage; TS_HEAD returns 33'h0.

Test Plan:
- Reset, then read STATUS → rdValid 1 cycle later; rdData = {1,16'h0,0,0,1,13'h0}. data_ready=0.
- Push I=32'h0000_1234, Q=32'hFFFF_FF00; read I_HEAD then Q_HEAD → 33'h1_0000_1234 then 33'h1_FFFF_FF00; fifo_count 1→0.
- With DEPTH=64, push 66 results → fifo_count=64, overflow=1, STATUS drop_count=2. Read FLUSH → returns count 64; afterwards fifo_count=0, overflow=0.
- Full FIFO, iq_valid in the same cycle as a Q_HEAD pop → count stays 64, no drop, new entry becomes the tail.
- Q_HEAD read on empty FIFO, and a read of offset +6 → both return 33'h0, rdValid pulses, pointers unchanged.
- With RESULT_TIMESTAMP_EN: push at cycle 100 then cycle 105; I_HEAD then TS_HEAD → timestamp of the first entry; after Q_HEAD, I_HEAD then TS_HEAD → timestamp of the second entry, which is 5 greater.

Source files
------------

// File: rtl/result_readback.sv
// Queues integrator I/Q results and serves them on the host read port; results arriving while full are dropped and counted.
// Reads answer exactly one cycle after rdEn; RESULT_TIMESTAMP_EN adds a per-entry 32-bit cycle timestamp (TS_HEAD).
module result_readback #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [13:0] ADDR_BASE = 14'h3F00
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        iq_valid,
  input  logic [31:0] i_val,
  input  logic [31:0] q_val,
  input  logic [13:0] MEM_sdi_mem_S_address,
  input  logic        MEM_sdi_mem_S_rdEn,
  output logic [32:0] MEM_sdi_mem_S_rdData,
  output logic        MEM_sdi_mem_S_rdValid,
  output logic [12:0] fifo_count,
  output logic        overflow,
  output logic        data_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
`ifdef RESULT_TIMESTAMP_EN
  localparam int unsigned EW = 96;
`else
  localparam int unsigned EW = 64;
`endif

  typedef enum logic {IDLE, HELD} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head, push_dat, hold_q, hold_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   used, used_after_rd, used_nxt;
  logic [12:0]   used13, fifo_count_q, fifo_count_d;
  logic [15:0]   drop_q, drop_d;
  logic [32:0]   rd_data_q, rd_data_d;
  logic [13:0]   offset;
  logic          empty, full, in_win, push_en;
  logic          overflow_q, overflow_d, rd_vld_q, rd_vld_d, data_ready_q, data_ready_d;
  state_t        state_q, state_d;
`ifdef RESULT_TIMESTAMP_EN
  logic [31:0]   ts_q, ts_d;
  assign ts_d     = ts_q + 32'd1;
  assign push_dat = {ts_q, i_val, q_val};
`else
  assign push_dat = {i_val, q_val};
`endif

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign head   = mem[rd_ptr_q[AW-1:0]];
  assign used   = wr_ptr_q - rd_ptr_q;
  assign used13 = 13'(used);
  assign empty  = (used == '0);
  assign full   = (used == DEPTH_P);
  assign offset = MEM_sdi_mem_S_address - ADDR_BASE;
  assign in_win = (MEM_sdi_mem_S_address >= ADDR_BASE) && (offset[13:3] == 11'd0);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    state_d       = state_q;
    hold_d        = hold_q;
    overflow_d    = overflow_q;
    drop_d        = drop_q;
    rd_data_d     = rd_data_q;
    rd_vld_d      = 1'b0;
    push_en       = 1'b0;
    used_after_rd = '0;
    used_nxt      = '0;

    if (MEM_sdi_mem_S_rdEn) begin
      rd_vld_d  = 1'b1;
      rd_data_d = '0;
      if (in_win) begin
        case (offset[2:0])
          3'd0: rd_data_d = {1'b1, drop_q, overflow_q, full, empty, used13};
          3'd1: if (!empty) begin
            hold_d    = head;
            rd_data_d = {1'b1, head[63:32]};
            state_d   = HELD;
          end
          3'd2: if (state_q == HELD && !empty) begin
            rd_data_d = {1'b1, hold_q[31:0]};
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            state_d   = IDLE;
          end else if (!empty) begin
            rd_data_d = {1'b1, head[31:0]};
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
          end
          3'd3: begin
            rd_data_d  = {1'b1, 19'b0, used13};
            rd_ptr_d   = wr_ptr_q;
            overflow_d = 1'b0;
            drop_d     = '0;
            state_d    = IDLE;
          end
`ifdef RESULT_TIMESTAMP_EN
          3'd4: if (state_q == HELD) rd_data_d = {1'b1, hold_q[95:64]};
`endif
          default: ;
        endcase
      end
    end

    // Any pop or flush in this cycle frees space before the push is judged.
    used_after_rd = wr_ptr_q - rd_ptr_d;
    if (iq_valid) begin
      if (used_after_rd != DEPTH_P) begin
        push_en  = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        overflow_d = 1'b1;
        if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
      end
    end

    used_nxt     = wr_ptr_d - rd_ptr_d;
    fifo_count_d = 13'(used_nxt);
    data_ready_d = (used_nxt != '0);
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= IDLE;
      hold_q       <= '0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      fifo_count_q <= '0;
      data_ready_q <= 1'b0;
`ifdef RESULT_TIMESTAMP_EN
      ts_q         <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
      fifo_count_q <= fifo_count_d;
      data_ready_q <= data_ready_d;
`ifdef RESULT_TIMESTAMP_EN
      ts_q         <= ts_d;
`endif
    end
  end

  always_ff @(posedge clk100) begin
    if (push_en) mem[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  assign MEM_sdi_mem_S_rdData  = rd_data_q;
  assign MEM_sdi_mem_S_rdValid = rd_vld_q;
  assign fifo_count            = fifo_count_q;
  assign overflow              = overflow_q;
  assign data_ready            = data_ready_q;
endmodule

// File: tb/tb_result_readback.sv
// Scoreboard bench for result_readback: a queue model predicts each read response, a negedge monitor compares.
module tb_result_readback;
  localparam int DEPTH = 64;
  localparam logic [13:0] BASE = 14'h3F00;

  logic        clk100 = 1'b0, reset = 1'b1, iq_valid = 1'b0, rd_en = 1'b0;
  logic [31:0] i_val = '0, q_val = '0;
  logic [13:0] addr = '0;
  logic [32:0] rd_data;
  logic        rd_valid, overflow, data_ready;
  logic [12:0] fifo_count;

  int compared = 0, mismatched = 0;

  typedef struct {
    logic [32:0] dat;
    bit          chk;
    string       name;
  } exp_t;
  exp_t        exp_q[$];
  logic [63:0] mdl[$];
  bit          m_held = 0, m_ovf = 0;
  logic [63:0] m_hold = '0;
  logic [15:0] m_drop = '0;
  logic [32:0] last_raw = '0;
  bit          req_d = 0;

  always #5 clk100 = ~clk100;

  result_readback #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk100(clk100), .reset(reset), .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val),
    .MEM_sdi_mem_S_address(addr), .MEM_sdi_mem_S_rdEn(rd_en),
    .MEM_sdi_mem_S_rdData(rd_data), .MEM_sdi_mem_S_rdValid(rd_valid),
    .fifo_count(fifo_count), .overflow(overflow), .data_ready(data_ready)
  );

  always @(posedge clk100) req_d <= rd_en;

  always @(negedge clk100) begin
    exp_t e;
    if (req_d) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_underflow: rdValid=%b with no prediction queued", rd_valid);
      end else begin
        e = exp_q.pop_front();
        last_raw = rd_data;
        if (rd_valid !== 1'b1) begin
          mismatched++;
          $display("FAIL %s rdValid: got %b want 1", e.name, rd_valid);
        end else if (e.chk && rd_data !== e.dat) begin
          mismatched++;
          $display("FAIL %s rdData: got %h want %h", e.name, rd_data, e.dat);
        end
      end
    end else if (rd_valid !== 1'b0) begin
      compared++;
      mismatched++;
      $display("FAIL stray_rdValid: got %b want 0", rd_valid);
    end
  end

  // One clock of stimulus; the model applies the read (pop/flush) before the push.
  task automatic cycle(input bit do_push, input logic [31:0] iv, input logic [31:0] qv,
                       input bit do_rd, input logic [13:0] a, input bit chk, input string nm);
    logic [32:0] e;
    logic [13:0] off;
    e   = '0;
    off = a - BASE;
    if (do_rd) begin
      if (a >= BASE && off < 14'd8) begin
        case (off[2:0])
          3'd0: e = {1'b1, m_drop, m_ovf, (mdl.size() == DEPTH), (mdl.size() == 0), 13'(mdl.size())};
          3'd1: if (mdl.size() > 0) begin
            m_hold = mdl[0];
            m_held = 1;
            e = {1'b1, mdl[0][63:32]};
          end
          3'd2: if (m_held) begin
            e = {1'b1, m_hold[31:0]};
            void'(mdl.pop_front());
            m_held = 0;
          end else if (mdl.size() > 0) begin
            e = {1'b1, mdl[0][31:0]};
            void'(mdl.pop_front());
          end
          3'd3: begin
            e = {1'b1, 19'b0, 13'(mdl.size())};
            mdl.delete();
            m_ovf  = 0;
            m_drop = '0;
            m_held = 0;
          end
          default: e = '0;
        endcase
      end
      exp_q.push_back('{e, chk, nm});
    end
    if (do_push) begin
      if (mdl.size() < DEPTH) mdl.push_back({iv, qv});
      else begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop++;
      end
    end
    iq_valid = do_push;
    i_val    = iv;
    q_val    = qv;
    rd_en    = do_rd;
    addr     = a;
    @(posedge clk100);
    #1;
    iq_valid = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    compared++;
    if (fifo_count !== 13'd0 || overflow !== 1'b0 || data_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: cnt=%0d ovf=%b rdy=%b want 0/0/0", fifo_count, overflow, data_ready);
    end
    compared++;
    if (rd_data !== 33'h0 || rd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_rd: data=%h vld=%b want 0/0", rd_data, rd_valid);
    end
    reset = 1'b0;
    cycle(0, 0, 0, 1, BASE, 1, "reset_status");
    idle(1);
  endtask

  task automatic test_single;
    cycle(1, 32'h0000_1234, 32'hFFFF_FF00, 0, BASE, 1, "");
    idle(1);
    compared++;
    if (fifo_count !== 13'd1 || data_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL single_cnt: cnt=%0d rdy=%b want 1/1", fifo_count, data_ready);
    end
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "single_i");
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "single_q");
    idle(2);
    compared++;
    if (fifo_count !== 13'd0 || data_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL single_drain: cnt=%0d rdy=%b want 0/0", fifo_count, data_ready);
    end
  endtask

  task automatic test_overflow;
    for (int k = 0; k < DEPTH + 2; k++) cycle(1, 32'hA000_0000 + 32'(k), ~32'(k), 0, BASE, 1, "");
    idle(1);
    compared++;
    if (fifo_count !== 13'd64 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_full: cnt=%0d ovf=%b want 64/1", fifo_count, overflow);
    end
    cycle(0, 0, 0, 1, BASE, 1, "ovf_status");
    cycle(0, 0, 0, 1, BASE + 14'd3, 1, "ovf_flush");
    idle(2);
    compared++;
    if (fifo_count !== 13'd0 || overflow !== 1'b0 || data_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_after_flush: cnt=%0d ovf=%b rdy=%b want 0/0/0", fifo_count, overflow, data_ready);
    end
  endtask

  task automatic test_full_push_pop;
    for (int k = 0; k < DEPTH; k++) cycle(1, 32'hB000_0000 + 32'(k), 32'h0B00_0000 + 32'(k), 0, BASE, 1, "");
    cycle(1, 32'hCAFE_0001, 32'hBEEF_0001, 1, BASE + 14'd2, 1, "fpp_pop");
    idle(1);
    compared++;
    if (fifo_count !== 13'd64 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL fpp_cnt: cnt=%0d ovf=%b want 64/0", fifo_count, overflow);
    end
    cycle(0, 0, 0, 1, BASE, 1, "fpp_status");
    for (int k = 0; k < DEPTH - 1; k++) cycle(0, 0, 0, 1, BASE + 14'd2, 1, "fpp_drain");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "fpp_tail_i");
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "fpp_tail_q");
    idle(2);
  endtask

  task automatic test_empty_reads;
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "empty_q");
    cycle(0, 0, 0, 1, BASE + 14'd6, 1, "off6");
    cycle(0, 0, 0, 1, 14'h0010, 1, "outside");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "empty_i");
    cycle(0, 0, 0, 1, BASE, 1, "empty_status");
    idle(1);
    compared++;
    if (fifo_count !== 13'd0) begin
      mismatched++;
      $display("FAIL empty_cnt: cnt=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) cycle(1, 32'h1111_0000 * 32'(k + 1), 32'h0000_2222 * 32'(k + 1), 0, BASE, 1, "");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "b2b_i0");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "b2b_relatch");
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "b2b_q0");
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "b2b_q1");
    cycle(0, 0, 0, 1, BASE, 1, "b2b_status");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "b2b_i2");
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "b2b_q2");
    idle(2);
    compared++;
    if (fifo_count !== 13'd0) begin
      mismatched++;
      $display("FAIL b2b_cnt: cnt=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_flush_push;
    for (int k = 0; k < 5; k++) cycle(1, 32'(k), 32'(k), 0, BASE, 1, "");
    cycle(1, 32'hDEAD_0000, 32'h0000_BEEF, 1, BASE + 14'd3, 1, "fp_flush");
    idle(1);
    compared++;
    if (fifo_count !== 13'd1) begin
      mismatched++;
      $display("FAIL fp_cnt: cnt=%0d want 1", fifo_count);
    end
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "fp_q");
    idle(2);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) cycle(1, 32'h5000 + 32'(k), 32'h6000 + 32'(k), 0, BASE, 1, "");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "rm_i");
    idle(1);
    reset = 1'b1;
    mdl.delete();
    m_ovf  = 0;
    m_drop = '0;
    m_held = 0;
    idle(2);
    reset = 1'b0;
    idle(1);
    compared++;
    if (fifo_count !== 13'd0 || data_ready !== 1'b0 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL rm_flags: cnt=%0d rdy=%b ovf=%b want 0/0/0", fifo_count, data_ready, overflow);
    end
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "rm_q_empty");
    cycle(0, 0, 0, 1, BASE, 1, "rm_status");
    idle(2);
  endtask

  task automatic test_timestamp;
`ifdef RESULT_TIMESTAMP_EN
    logic [32:0] ts1, ts2;
    cycle(1, 32'h7000_0001, 32'h7100_0001, 0, BASE, 1, "");
    idle(4);
    cycle(1, 32'h7000_0002, 32'h7100_0002, 0, BASE, 1, "");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "ts_i0");
    cycle(0, 0, 0, 1, BASE + 14'd4, 0, "ts_t0");
    idle(1);
    ts1 = last_raw;
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "ts_q0");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "ts_i1");
    cycle(0, 0, 0, 1, BASE + 14'd4, 0, "ts_t1");
    idle(1);
    ts2 = last_raw;
    compared++;
    if (ts1[32] !== 1'b1 || ts2[32] !== 1'b1 || (ts2[31:0] - ts1[31:0]) !== 32'd5) begin
      mismatched++;
      $display("FAIL ts_delta: ts1=%h ts2=%h want flags set and delta 5", ts1, ts2);
    end
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "ts_q1");
    cycle(0, 0, 0, 1, BASE + 14'd4, 1, "ts_idle");
    idle(2);
`else
    cycle(1, 32'h7000_0001, 32'h7100_0001, 0, BASE, 1, "");
    cycle(0, 0, 0, 1, BASE + 14'd1, 1, "ts_i0");
    cycle(0, 0, 0, 1, BASE + 14'd4, 1, "ts_off");
    cycle(0, 0, 0, 1, BASE + 14'd2, 1, "ts_q0");
    idle(2);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_empty_reads();
    test_back_to_back();
    test_flush_push();
    test_reset_mid();
    test_timestamp();
    idle(2);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: %0d responses never arrived, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
